// File: rtl/alu_op_sched.sv
// Round-robin sequencer in front of a combinational 4-bit ALU: accepts one of two
// requesters, drives the ALU from registers for one cycle, and returns a tagged response.
module alu_op_sched #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [2:0]       alu_select,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  input  logic [WIDTH-1:0] alu_and1,
  input  logic [WIDTH-1:0] alu_or1,
  input  logic [WIDTH-1:0] alu_sum,
  input  logic [WIDTH-1:0] alu_sub,
  input  logic [WIDTH-1:0] alu_xor1,
  input  logic             alu_carry,
  input  logic             alu_borrow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_flag,
  output logic             rsp_err,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_last_grant;
  logic [2:0]         r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_id;
  logic [WIDTH-1:0]   r_rsp_data;
  logic               r_rsp_flag;
  logic               r_rsp_err;
  logic [CNT_W-1:0]   r_count;

  logic               w_grant;
  logic               w_accept;
  logic               w_rsp_done;
  logic [WIDTH+1:0]   w_result;

  // Packs {err, flag, data} for the opcode currently presented to the ALU.
  function automatic logic [WIDTH+1:0] f_result(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] and1,
    input logic [WIDTH-1:0] or1,
    input logic [WIDTH-1:0] sum,
    input logic [WIDTH-1:0] sub,
    input logic [WIDTH-1:0] xor1,
    input logic             carry,
    input logic             borrow
  );
    logic [WIDTH+1:0] res;
    case (op)
      3'b000:  res = {1'b0, 1'b0, and1};
      3'b001:  res = {1'b0, 1'b0, or1};
      3'b010:  res = {1'b0, carry, sum};
      3'b011:  res = {1'b0, borrow, sub};
      3'b100:  res = {1'b0, 1'b0, xor1};
      default: res = {1'b1, 1'b0, {WIDTH{1'b0}}};
    endcase
    return res;
  endfunction

  // Under contention the requester that was not served last wins.
  always_comb begin
    w_grant = 1'b0;
    if (req0_valid && req1_valid) begin
      w_grant = ~r_last_grant;
    end else if (req1_valid) begin
      w_grant = 1'b1;
    end
  end

  assign w_result = f_result(r_op, alu_and1, alu_or1, alu_sum, alu_sub, alu_xor1,
                             alu_carry, alu_borrow);

  always_comb begin
    w_state_nxt = r_state;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    rsp_valid   = 1'b0;
    w_accept    = 1'b0;
    w_rsp_done  = 1'b0;
    case (r_state)
      IDLE: begin
        req0_ready = req0_valid && !w_grant;
        req1_ready = req1_valid && w_grant;
        if (req0_valid || req1_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = EXEC;
        end
      end
      EXEC: w_state_nxt = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_rsp_done  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_op         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_id         <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_flag   <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_count      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op         <= w_grant ? req1_op : req0_op;
        r_a          <= w_grant ? req1_a  : req0_a;
        r_b          <= w_grant ? req1_b  : req0_b;
        r_id         <= w_grant;
        r_last_grant <= w_grant;
      end
      if (r_state == EXEC) begin
        r_rsp_err  <= w_result[WIDTH+1];
        r_rsp_flag <= w_result[WIDTH];
        r_rsp_data <= w_result[WIDTH-1:0];
      end
      if (w_rsp_done) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign alu_select = r_op;
  assign alu_in1    = r_a;
  assign alu_in2    = r_b;
  assign rsp_id     = r_id;
  assign rsp_data   = r_rsp_data;
  assign rsp_flag   = r_rsp_flag;
  assign rsp_err    = r_rsp_err;
  assign op_count   = r_count;

endmodule

// File: tb/tb_alu_op_sched.sv
// Directed bench for alu_op_sched with a behavioural 4-bit ALU attached to its ALU port.
module tb_alu_op_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [2:0] req0_op = '0, req1_op = '0;
  logic [3:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [2:0] alu_select;
  logic [3:0] alu_in1, alu_in2;
  logic [3:0] alu_and1, alu_or1, alu_sum, alu_sub, alu_xor1;
  logic       alu_carry, alu_borrow;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic       rsp_id;
  logic [3:0] rsp_data;
  logic       rsp_flag, rsp_err;
  logic [7:0] op_count;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign {alu_carry, alu_sum} = {1'b0, alu_in1} + {1'b0, alu_in2};
  assign alu_sub    = alu_in1 - alu_in2;
  assign alu_borrow = (alu_in1 < alu_in2);
  assign alu_and1   = alu_in1 & alu_in2;
  assign alu_or1    = alu_in1 | alu_in2;
  assign alu_xor1   = alu_in1 ^ alu_in2;

  alu_op_sched #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_select(alu_select), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_and1(alu_and1), .alu_or1(alu_or1), .alu_sum(alu_sum),
    .alu_sub(alu_sub), .alu_xor1(alu_xor1),
    .alu_carry(alu_carry), .alu_borrow(alu_borrow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_flag(rsp_flag), .rsp_err(rsp_err),
    .op_count(op_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expects IDLE with the request inputs already applied and rsp_ready=1.
  task automatic run_op(input logic id, input logic [2:0] op, input logic [3:0] a,
                        input logic [3:0] b, input logic [3:0] d, input logic f,
                        input logic e, input logic [7:0] cnt);
    #1;
    chk("req0_ready_idle", req0_ready, !id);
    chk("req1_ready_idle", req1_ready, id);
    tick();
    chk("exec_rsp_valid", rsp_valid, 0);
    chk("exec_select", alu_select, op);
    chk("exec_in1", alu_in1, a);
    chk("exec_in2", alu_in2, b);
    chk("exec_ready", {req0_ready, req1_ready}, 0);
    tick();
    chk("resp_valid", rsp_valid, 1);
    chk("resp_id", rsp_id, id);
    chk("resp_data", rsp_data, d);
    chk("resp_flag", rsp_flag, f);
    chk("resp_err", rsp_err, e);
    chk("resp_ready", {req0_ready, req1_ready}, 0);
    tick();
    chk("done_rsp_valid", rsp_valid, 0);
    chk("done_count", op_count, cnt);
  endtask

  initial begin
    #3;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_count", op_count, 0);
    chk("rst_alu", {alu_select, alu_in1, alu_in2}, 0);
    chk("rst_rsp", {rsp_id, rsp_data, rsp_flag, rsp_err}, 0);
    #9 rst_n = 1'b1;
    tick();

    // Single requester 0: AND
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_op = 3'b000; req0_a = 4'b1010; req0_b = 4'b1100;
    run_op(1'b0, 3'b000, 4'b1010, 4'b1100, 4'b1000, 1'b0, 1'b0, 8'd1);
    req0_valid = 1'b0;

    // Requester 1: ADD with carry, SUB without and with borrow
    req1_valid = 1'b1; req1_op = 3'b010; req1_a = 4'b1010; req1_b = 4'b1110;
    run_op(1'b1, 3'b010, 4'b1010, 4'b1110, 4'b1000, 1'b1, 1'b0, 8'd2);
    req1_op = 3'b011; req1_a = 4'b1110; req1_b = 4'b1000;
    run_op(1'b1, 3'b011, 4'b1110, 4'b1000, 4'b0110, 1'b0, 1'b0, 8'd3);
    req1_op = 3'b011; req1_a = 4'b0010; req1_b = 4'b0100;
    run_op(1'b1, 3'b011, 4'b0010, 4'b0100, 4'b1110, 1'b1, 1'b0, 8'd4);

    // Contention: grants alternate 0,1,0,1
    req0_valid = 1'b1; req0_op = 3'b001; req0_a = 4'b1011; req0_b = 4'b1110;
    req1_valid = 1'b1; req1_op = 3'b100; req1_a = 4'b0010; req1_b = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0)
        run_op(1'b0, 3'b001, 4'b1011, 4'b1110, 4'b1111, 1'b0, 1'b0, 8'(5 + i));
      else
        run_op(1'b1, 3'b100, 4'b0010, 4'b0100, 4'b0110, 1'b0, 1'b0, 8'(5 + i));
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Back-pressure on the response channel
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_op = 3'b000; req0_a = 4'b1111; req0_b = 4'b0101;
    tick();
    req0_valid = 1'b0; req1_valid = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", rsp_valid, 1);
      chk("hold_data", {rsp_id, rsp_data, rsp_flag, rsp_err}, {1'b0, 4'b0101, 1'b0, 1'b0});
      chk("hold_ready", {req0_ready, req1_ready}, 0);
      chk("hold_count", op_count, 8);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    tick();
    chk("release_valid", rsp_valid, 0);
    chk("release_count", op_count, 9);
    req1_valid = 1'b0;

    // Illegal opcode
    req1_valid = 1'b1; req1_op = 3'b110; req1_a = 4'b0011; req1_b = 4'b0101;
    run_op(1'b1, 3'b110, 4'b0011, 4'b0101, 4'b0000, 1'b0, 1'b1, 8'd10);

    // Asynchronous reset during EXEC
    req1_op = 3'b010; req1_a = 4'b0001; req1_b = 4'b0001;
    tick();
    chk("pre_rst_select", alu_select, 3'b010);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_alu", {alu_select, alu_in1, alu_in2}, 0);
    chk("arst_rsp", {rsp_valid, rsp_id, rsp_data, rsp_flag, rsp_err}, 0);
    chk("arst_count", op_count, 0);
    #2 rst_n = 1'b1;
    req0_valid = 1'b1; req0_op = 3'b000; req0_a = 4'b0110; req0_b = 4'b0011;
    #1;
    chk("post_rst_valid", rsp_valid, 0);
    run_op(1'b0, 3'b000, 4'b0110, 4'b0011, 4'b0010, 1'b0, 1'b0, 8'd1);
    run_op(1'b1, 3'b010, 4'b0001, 4'b0001, 4'b0010, 1'b0, 1'b0, 8'd2);
    req0_valid = 1'b0; req1_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
